spi_slave_rx_frame: RTL and testbench

//   SPI mode-0 slave receive/transmit core for the slave side of the SPI unit.

---
 rtl/spi_slave_rx_frame.sv | 156 +++++++++++++++
 tb/tb_spi_slave_rx_frame.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_frame.sv
// SPI mode-0 slave core: oversampled sclk/ss_n/mosi, MSB-first bytes grouped
// into multi-byte frames, with tx_data shifted out on miso in the same transfer.
module spi_slave_rx_frame #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8,
    parameter int FRAME_BYTES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sclk,
    input  logic                          ss_n,
    input  logic                          mosi,
    output logic                          miso,
    input  logic [DATA_W-1:0]             tx_data,
    output logic [DATA_W-1:0]             rx_byte,
    output logic                          rx_byte_valid,
    output logic [DATA_W*FRAME_BYTES-1:0] frame_data,
    output logic                          frame_valid,
    output logic                          frame_err
);

    localparam int FW = DATA_W * FRAME_BYTES;
    localparam int BW = $clog2(DATA_W + 1);
    localparam int CW = $clog2(FRAME_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CLOSE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES:0]   sclk_q;
    logic [SYNC_STAGES:0]   ss_q;
    logic [SYNC_STAGES-1:0] mosi_q;

    logic [BW-1:0]     bit_cnt;
    logic [CW-1:0]     byte_cnt;
    logic [CW-1:0]     byte_after;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [FW-1:0]     frame_sr;
    logic [FW-1:0]     frame_nx;

    logic sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;
    logic done, last;
    logic do_load, do_shift_in, do_shift_out, err_n;

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
    assign ss_fall   = ~ss_q[SYNC_STAGES-1] & ss_q[SYNC_STAGES];
    assign ss_rise   = ss_q[SYNC_STAGES-1] & ~ss_q[SYNC_STAGES];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];

    assign done     = (bit_cnt == BW'(DATA_W));
    assign last     = (byte_cnt == CW'(FRAME_BYTES - 1));
    assign frame_nx = (frame_sr << DATA_W) | FW'(rx_sr);
    assign miso     = (state == SHIFT) ? tx_sr[DATA_W-1] : 1'b0;

    // Sync regs reset low so an ss_n held low across reset shows no falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q <= '0;
            ss_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
            ss_q   <= {ss_q[SYNC_STAGES-1:0], ss_n};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
        end
    end

    always_comb begin
        state_n      = state;
        do_load      = 1'b0;
        do_shift_in  = 1'b0;
        do_shift_out = 1'b0;
        err_n        = 1'b0;
        byte_after   = byte_cnt;
        if (done) begin
            byte_after = last ? '0 : byte_cnt + CW'(1);
        end
        unique case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_n = SHIFT;
                    do_load = 1'b1;
                end
            end
            SHIFT: begin
                do_shift_in = sclk_rise;
                // The fall right after a byte completes must not eat the reloaded MSB.
                do_shift_out = sclk_fall && (bit_cnt != '0) && !done;
                if (ss_rise) begin
                    state_n = CLOSE;
                end
            end
            CLOSE: begin
                state_n = IDLE;
                err_n   = (!done && bit_cnt != '0) || (byte_after != '0);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            frame_sr      <= '0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            frame_data    <= '0;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state         <= state_n;
            rx_byte_valid <= 1'b0;
            frame_valid   <= 1'b0;
            frame_err     <= err_n;
            if (do_load) begin
                tx_sr    <= tx_data;
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end
            if (do_shift_out) begin
                tx_sr <= tx_sr << 1;
            end
            if (done) begin
                rx_byte       <= rx_sr;
                rx_byte_valid <= 1'b1;
                tx_sr         <= tx_data;
                bit_cnt       <= '0;
                frame_sr      <= frame_nx;
                byte_cnt      <= byte_after;
                if (last) begin
                    frame_data  <= frame_nx;
                    frame_valid <= 1'b1;
                end
            end
            if (do_shift_in) begin
                rx_sr   <= {rx_sr[DATA_W-2:0], mosi_s};
                bit_cnt <= done ? BW'(1) : bit_cnt + BW'(1);
            end
            if (state == CLOSE) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx_frame.sv
// Bench for spi_slave_rx_frame: directed and random SPI windows checked
// against a byte/frame-level model of the transfer.
module tb_spi_slave_rx_frame;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk, ss_n, mosi, miso;
    logic [7:0]  tx_data, rx_byte;
    logic        rx_byte_valid, frame_valid, frame_err;
    logic [15:0] frame_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ob[$];
    logic [15:0] of[$];
    int          oerr;

    logic [7:0]  m_rx;
    logic [15:0] m_frame;

    always #5 clk = ~clk;

    spi_slave_rx_frame #(
        .SYNC_STAGES(2),
        .DATA_W(8),
        .FRAME_BYTES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sclk(sclk),
        .ss_n(ss_n),
        .mosi(mosi),
        .miso(miso),
        .tx_data(tx_data),
        .rx_byte(rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .frame_data(frame_data),
        .frame_valid(frame_valid),
        .frame_err(frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_byte_valid) ob.push_back(rx_byte);
            if (frame_valid) begin
                of.push_back(frame_data);
                chk("fv_with_bv", {31'd0, rx_byte_valid}, 32'd1);
            end
            if (frame_err) oerr++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bits(input logic [7:0] bytes[$], input int nbits,
                             input int half, input bit close_on_rise);
        for (int i = 0; i < nbits; i++) begin
            logic [7:0] cur;
            cur  = bytes[i/8];
            mosi = cur[7-(i%8)];
            wait_clk(half);
            #1;
            chk("miso", {31'd0, miso}, {31'd0, tx_data[7-(i%8)]});
            sclk = 1'b1;
            if (close_on_rise && i == nbits - 1) ss_n = 1'b1;
            wait_clk(half);
            #1;
            sclk = 1'b0;
        end
    endtask

    // Model: whole bytes are received in order, every pair forms a frame,
    // and any leftover bits or odd byte at ss_n release is an error.
    task automatic xfer(input logic [7:0] bytes[$], input int nbits,
                        input int half, input bit close_on_rise);
        logic [7:0]  eb[$];
        logic [15:0] ef[$];
        int          nb;
        ob.delete();
        of.delete();
        oerr = 0;
        ss_n = 1'b0;
        wait_clk(half + 2);
        #1;
        send_bits(bytes, nbits, half, close_on_rise);
        if (!close_on_rise) begin
            wait_clk(half);
            #1;
            ss_n = 1'b1;
        end
        wait_clk(14);
        #1;
        nb = nbits / 8;
        for (int j = 0; j < nb; j++) begin
            eb.push_back(bytes[j]);
            m_rx = bytes[j];
            if (j % 2 == 1) begin
                m_frame = {bytes[j-1], bytes[j]};
                ef.push_back(m_frame);
            end
        end
        chk("n_bytes", ob.size(), eb.size());
        for (int j = 0; j < eb.size() && j < ob.size(); j++)
            chk("rx_byte", {24'd0, ob[j]}, {24'd0, eb[j]});
        chk("n_frames", of.size(), ef.size());
        for (int j = 0; j < ef.size() && j < of.size(); j++)
            chk("frame", {16'd0, of[j]}, {16'd0, ef[j]});
        chk("frame_err", oerr, (nbits % 16 != 0) ? 1 : 0);
        chk("rx_hold", {24'd0, rx_byte}, {24'd0, m_rx});
        chk("frame_hold", {16'd0, frame_data}, {16'd0, m_frame});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rx"}, {24'd0, rx_byte}, 32'd0);
        chk({tag, "_frame"}, {16'd0, frame_data}, 32'd0);
        chk({tag, "_pulses"}, {29'd0, rx_byte_valid, frame_valid, frame_err}, 32'd0);
        chk({tag, "_miso"}, {31'd0, miso}, 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        int nby, nbits, half;
        bit cor;
        reset   = 1'b1;
        sclk    = 1'b0;
        ss_n    = 1'b1;
        mosi    = 1'b0;
        tx_data = 8'h00;
        m_rx    = 8'h00;
        m_frame = 16'h0000;
        wait_clk(4);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        wait_clk(4);
        #1;

        tx_data = 8'($urandom);
        q = '{8'hA5, 8'h3C};
        xfer(q, 16, 4, 1'b0);

        tx_data = 8'h96;
        q = '{8'h5A};
        xfer(q, 8, 4, 1'b0);

        tx_data = 8'($urandom);
        q = '{8'hFF};
        xfer(q, 5, 4, 1'b0);

        q = '{8'h01, 8'h02, 8'h03, 8'h04};
        xfer(q, 32, 5, 1'b0);

        q = '{8'hC3, 8'h7E};
        xfer(q, 16, 4, 1'b1);

        ob.delete();
        of.delete();
        oerr = 0;
        for (int i = 0; i < 20; i++) begin
            mosi = 1'($urandom);
            sclk = ~sclk;
            wait_clk(4);
            #1;
            chk("idle_miso", {31'd0, miso}, 32'd0);
        end
        sclk = 1'b0;
        wait_clk(8);
        #1;
        chk("idle_pulses", ob.size() + of.size() + oerr, 0);

        tx_data = 8'($urandom);
        q = '{8'h81, 8'h42};
        ss_n = 1'b0;
        wait_clk(6);
        #1;
        send_bits(q, 8, 4, 1'b0);
        wait_clk(8);
        #1;
        reset = 1'b1;
        wait_clk(2);
        #1;
        reset = 1'b0;
        chk_zero("mid_reset");
        m_rx    = 8'h00;
        m_frame = 16'h0000;
        ob.delete();
        of.delete();
        oerr = 0;
        for (int i = 0; i < 32; i++) begin
            sclk = ~sclk;
            wait_clk(4);
            #1;
        end
        ss_n = 1'b1;
        wait_clk(10);
        #1;
        chk("no_frame_after_reset", ob.size() + of.size() + oerr, 0);
        chk_zero("post_reset");

        for (int w = 0; w < 12; w++) begin
            q.delete();
            nby = $urandom_range(1, 4);
            for (int j = 0; j < nby; j++) q.push_back(8'($urandom));
            nbits = nby * 8;
            if ($urandom_range(0, 2) == 0) nbits = nbits - $urandom_range(1, 7);
            half = $urandom_range(4, 7);
            cor = 1'($urandom);
            tx_data = 8'($urandom);
            xfer(q, nbits, half, cor);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
